// File: rtl/pqr5_wbu.sv
// PQR5 writeback unit: formats retiring results, drives the single RF write port,
// exposes two forwarding slots covering the synchronous-read window, counts retirements.
module pqr5_wbu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_vld,
  output logic            o_rdy,
  input  logic            i_halt,
  input  logic            i_wb_en,
  input  logic            i_is_ld,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lsb,
  input  logic [4:0]      i_rdt_addr,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic [XLEN-1:0] i_ld_data,
  output logic            o_wren,
  output logic [4:0]      o_rdt_addr,
  output logic [XLEN-1:0] o_rdt_data,
  output logic            o_fwd0_vld,
  output logic [4:0]      o_fwd0_addr,
  output logic [XLEN-1:0] o_fwd0_data,
  output logic            o_fwd1_vld,
  output logic [4:0]      o_fwd1_addr,
  output logic [XLEN-1:0] o_fwd1_data,
  output logic [63:0]     o_instret
);

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_op_e;

  logic            accept;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;
  logic [XLEN-1:0] wb_data;

  logic            wren_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] data_q;
  logic            fwd1_vld_q;
  logic [4:0]      fwd1_addr_q;
  logic [XLEN-1:0] fwd1_data_q;
  logic [63:0]     instret_q;

  assign o_rdy  = aresetn & ~i_halt;
  assign accept = i_vld & o_rdy;

  always_comb begin
    ld_byte = i_ld_data[7:0];
    case (i_addr_lsb)
      2'd1:    ld_byte = i_ld_data[15:8];
      2'd2:    ld_byte = i_ld_data[23:16];
      2'd3:    ld_byte = i_ld_data[31:24];
      default: ld_byte = i_ld_data[7:0];
    endcase
    // Halfword lane selected by bit 1 only; odd addresses never reach here.
    ld_half = i_addr_lsb[1] ? i_ld_data[31:16] : i_ld_data[15:0];
  end

  always_comb begin
    ld_fmt = i_ld_data;
    case (ld_op_e'(i_funct3))
      LD_B:    ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      LD_BU:   ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      LD_H:    ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      LD_HU:   ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = i_ld_data;
    endcase
    wb_data = i_is_ld ? ld_fmt : i_alu_res;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      fwd1_vld_q  <= 1'b0;
      fwd1_addr_q <= '0;
      fwd1_data_q <= '0;
      instret_q   <= '0;
    end else begin
      wren_q <= accept & i_wb_en & (i_rdt_addr != '0);
      if (accept) begin
        addr_q    <= i_rdt_addr;
        data_q    <= wb_data;
        instret_q <= instret_q + 64'd1;
      end
      // Slot 1 trails the write port by exactly one cycle, independent of accept.
      fwd1_vld_q  <= wren_q;
      fwd1_addr_q <= addr_q;
      fwd1_data_q <= data_q;
    end
  end

  assign o_wren      = wren_q;
  assign o_rdt_addr  = addr_q;
  assign o_rdt_data  = data_q;
  assign o_fwd0_vld  = wren_q;
  assign o_fwd0_addr = addr_q;
  assign o_fwd0_data = data_q;
  assign o_fwd1_vld  = fwd1_vld_q;
  assign o_fwd1_addr = fwd1_addr_q;
  assign o_fwd1_data = fwd1_data_q;
  assign o_instret   = instret_q;

endmodule
